// File: rtl/input_buffer.sv
// Multi-channel frame capture buffer: on a start pulse it records LENGTH
// samples from each of NSINK channels, then replays them as one packetised
// stream (one packet per channel, channel order, sop/eop/valid framing).
module input_buffer #(
  parameter int NSINK  = 3,
  parameter int WIDTH  = 14,
  parameter int LENGTH = 2048
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sink_start,
  input  logic [WIDTH-1:0] sink_data [NSINK],
  output logic             source_valid,
  output logic             source_sop,
  output logic             source_eop,
  output logic [WIDTH-1:0] source_data
);

  localparam int AW  = $clog2(LENGTH);
  localparam int CHW = (NSINK > 1) ? $clog2(NSINK) : 1;
  // One spare bit so the counter can reach NSINK*LENGTH (the drain cycle).
  localparam int CW  = AW + CHW + 1;

  localparam logic [CW-1:0] LAST_CAP = CW'(LENGTH - 1);
  localparam logic [CW-1:0] TOTAL    = CW'(NSINK * LENGTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   idx;
  logic [CHW-1:0]  ch;

  // Stage 1: RAM read data plus the framing that belongs to it.
  logic            s1_valid_q;
  logic            s1_sop_q;
  logic            s1_eop_q;
  logic [CHW-1:0]  s1_ch_q;
  logic [WIDTH-1:0] bank_rd [NSINK];
  logic [WIDTH-1:0] s1_word;

  // Stage 2: output registers.
  logic             valid_q;
  logic             sop_q;
  logic             eop_q;
  logic [WIDTH-1:0] data_q;

  // A single counter serves as the capture index and as the {channel, index}
  // readout address; it is zero whenever the FSM sits in IDLE.
  assign idx = cnt_q[AW-1:0];
  assign ch  = cnt_q[AW +: CHW];

  // Next-state logic: capture LENGTH samples, read NSINK*LENGTH words, then
  // spend one extra OUTPUT cycle while the last word drains to the outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sink_start) begin
          wr_en   = 1'b1;
          cnt_d   = CW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (cnt_q == LAST_CAP) begin
          cnt_d   = '0;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUTPUT: begin
        if (cnt_q == TOTAL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rd_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // One RAM bank per channel, all written at the same index; registered read.
  genvar gi;
  generate
    for (gi = 0; gi < NSINK; gi++) begin : g_bank
      logic [WIDTH-1:0] mem [LENGTH];
      logic [WIDTH-1:0] rd_q;

      // Bank write on capture, registered read during readout.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[idx] <= sink_data[gi];
        end
        if (rd_en) begin
          rd_q <= mem[idx];
        end
      end

      assign bank_rd[gi] = rd_q;
    end
  endgenerate

  // Select the bank whose channel was addressed one cycle earlier.
  always_comb begin
    s1_word = '0;
    for (int c = 0; c < NSINK; c++) begin
      if (s1_ch_q == CHW'(c)) begin
        s1_word = bank_rd[c];
      end
    end
  end

  // State, counter and the two-stage framing/data pipeline.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_ch_q    <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= rd_en;
      s1_sop_q   <= rd_en && (idx == '0);
      s1_eop_q   <= rd_en && (idx == LAST_IDX);
      s1_ch_q    <= ch;
      valid_q    <= s1_valid_q;
      sop_q      <= s1_sop_q;
      eop_q      <= s1_eop_q;
      data_q     <= s1_valid_q ? s1_word : '0;
    end
  end

  assign source_valid = valid_q;
  assign source_sop   = sop_q;
  assign source_eop   = eop_q;
  assign source_data  = data_q;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer with NSINK=3, WIDTH=14, LENGTH=8.
module tb_input_buffer;

  localparam int NS = 3;
  localparam int W  = 14;
  localparam int L  = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sink_start;
  logic [W-1:0] sink_data [NS];
  logic         source_valid;
  logic         source_sop;
  logic         source_eop;
  logic [W-1:0] source_data;

  int checks = 0;
  int errors = 0;

  // Expected frame contents, filled by the bench before each capture.
  logic [W-1:0] exp_mem [NS][L];

  input_buffer #(
    .NSINK (NS),
    .WIDTH (W),
    .LENGTH(L)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sink_start  (sink_start),
    .sink_data   (sink_data),
    .source_valid(source_valid),
    .source_sop  (source_sop),
    .source_eop  (source_eop),
    .source_data (source_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int seed);
    for (int c = 0; c < NS; c++) begin
      for (int i = 0; i < L; i++) begin
        exp_mem[c][i] = W'(seed + c * 100 + i);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_valid", source_valid, 0);
      chk("idle_data", source_data, 0);
    end
  endtask

  // Drives L capture edges (start on the first); optional extra start pulse.
  task automatic capture(input int pulse_i);
    for (int i = 0; i < L; i++) begin
      sink_start = (i == 0) || (i == pulse_i);
      for (int c = 0; c < NS; c++) sink_data[c] = exp_mem[c][i];
      step();
      chk("cap_valid", source_valid, 0);
      chk("cap_data", source_data, 0);
    end
    sink_start = 1'b0;
    for (int c = 0; c < NS; c++) sink_data[c] = W'(14'h2AAA + c);
  endtask

  // Checks the readout; optional start pulse or reset before word pulse_k/rst_k.
  task automatic check_frame(input int pulse_k, input int rst_k);
    step();
    chk("pre_valid", source_valid, 0);
    for (int k = 0; k < NS * L; k++) begin
      if (k == pulse_k) sink_start = 1'b1;
      if (k == rst_k) reset_n = 1'b0;
      step();
      sink_start = 1'b0;
      if (k == rst_k) begin
        chk("rst_valid", source_valid, 0);
        chk("rst_sop", source_sop, 0);
        chk("rst_eop", source_eop, 0);
        chk("rst_data", source_data, 0);
        return;
      end
      chk($sformatf("w%0d_valid", k), source_valid, 1);
      chk($sformatf("w%0d_sop", k), source_sop, ((k % L) == 0) ? 1 : 0);
      chk($sformatf("w%0d_eop", k), source_eop, ((k % L) == (L - 1)) ? 1 : 0);
      chk($sformatf("w%0d_data", k), source_data, exp_mem[k / L][k % L]);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    sink_start = 1'b0;
    for (int c = 0; c < NS; c++) sink_data[c] = '0;

    // Reset held for 3 cycles while sink_start toggles.
    for (int i = 0; i < 3; i++) begin
      sink_start = (i % 2 == 0);
      step();
      chk("reset_valid", source_valid, 0);
      chk("reset_sop", source_sop, 0);
      chk("reset_eop", source_eop, 0);
      chk("reset_data", source_data, 0);
    end
    sink_start = 1'b0;
    reset_n    = 1'b1;
    idle_cycles(40);

    // Basic frame: c*100 + idx.
    fill(0);
    capture(-1);
    check_frame(-1, -1);
    idle_cycles(2);

    // Signed pass-through on channel 0.
    fill(0);
    exp_mem[0][0] = 14'h2000;
    exp_mem[0][1] = 14'h1FFF;
    exp_mem[0][2] = 14'h3FFF;
    capture(-1);
    check_frame(-1, -1);
    idle_cycles(2);

    // Start pulses at E0+3 and E0+15 are ignored; exactly one frame.
    fill(1000);
    capture(3);
    check_frame(6, -1);
    idle_cycles(40);

    // Back-to-back frames: second start on the edge after the last word.
    fill(2000);
    capture(-1);
    check_frame(-1, -1);
    fill(3000);
    capture(-1);
    check_frame(-1, -1);
    idle_cycles(2);

    // Reset at E0+12 aborts the readout.
    fill(500);
    capture(-1);
    check_frame(-1, 3);
    step();
    chk("rst_hold_valid", source_valid, 0);
    reset_n = 1'b1;
    idle_cycles(40);
    fill(600);
    capture(-1);
    check_frame(-1, -1);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
Name: input_buffer

Overview:
- Multi-channel frame capture buffer sitting between the sampled-data front end and the streaming processing chain (FFT-style packet consumer).
- Triggered by a start pulse, it records LENGTH consecutive samples from each of NSINK parallel channels into internal RAM.
- It then replays them as a single-lane packetised stream: one packet per channel, in channel order, with sop, eop and valid framing.

Parameters:
- NSINK, 3, number of parallel input channels (≥1).
- WIDTH, 14, sample width in bits (two's-complement; passed through bit-exact).
- LENGTH, 2048, samples per channel per frame; power of two, ≥2. Address width is clog2(LENGTH).

Ports:
- clk  input  1  single clock for capture and readout.
- reset_n  input  1  synchronous, active-low reset.
- sink_start  input  1  frame trigger, sampled on rising clk edge.
- sink_data  input  [NSINK] x WIDTH  unpacked array, element 0..NSINK-1, one sample per channel per cycle.
- source_valid  output  1  source_data carries a frame word.
- source_sop  output  1  first word of a channel packet.
- source_eop  output  1  last word of a channel packet.
- source_data  output  WIDTH  output sample.

Behaviour:
- One clock domain. Reset is synchronous and active-low. All outputs are registered.
- Reset (reset_n=0 at an edge):
  - state goes to IDLE;
  - source_valid, source_sop, source_eop and source_data all go to 0;
  - all counters clear.
  - Reset asserted mid-capture or mid-readout aborts the frame. No partial output follows reset release.
- FSM states: IDLE -> CAPTURE -> OUTPUT -> IDLE.
- IDLE:
  - Outputs are 0.
  - An edge with sink_start=1 writes sink_data[c] to RAM slot (c, 0) for every c, and moves to CAPTURE with sample index 1.
- CAPTURE:
  - Each edge writes sink_data[c] to slot (c, idx) for all c.
  - After the edge writing idx = LENGTH-1, the FSM goes to OUTPUT.
  - sink_start is ignored in this state.
- OUTPUT:
  - Reads slots in order (ch0, idx 0..LENGTH-1), then (ch1, ...), through to (ch NSINK-1).
  - Produces one word per clock with no gaps. There is no backpressure.
  - The RAM has 1-cycle read latency. Output registers are aligned so sop, eop and data refer to the same word.
  - sink_start is ignored in this state.
- Timing: let E0 be the edge where start is accepted.
  - Word k (k = 0..NSINK*LENGTH-1) appears at source outputs after edge E0 + LENGTH + 1 + k.
  - source_valid=1 for exactly NSINK*LENGTH consecutive cycles.
- Framing within the stream:
  - source_sop=1 when k mod LENGTH = 0.
  - source_eop=1 when k mod LENGTH = LENGTH-1.
  - sop and eop are never both 1, since LENGTH ≥ 2.
- Return to IDLE:
  - The FSM re-enters IDLE on the edge that presents the last word.
  - The edge after that drives source_valid, sop, eop and source_data to 0.
  - A start sampled on that next edge or later is accepted. Frames may therefore repeat with minimum period LENGTH*(NSINK+1)+1 cycles.
- While source_valid=0, source_data=0.
- Storage: NSINK*LENGTH*WIDTH bits. Implement as inferable block RAM with address {channel, index}; one write port of NSINK*WIDTH width, or NSINK banks.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles while toggling sink_start -> all outputs 0; no frame emitted after release.
- Basic frame (NSINK=3, WIDTH=14, LENGTH=8): assert start for 1 cycle with sink_data[c] = c*100 + idx -> first valid word at E0+9 is 0, with sop=1.
  - Following words: 1..7, eop on 7; then 100..107 with sop/eop; then 200..207.
  - 24 valid cycles total, then valid drops.
- Signed pass-through: drive -8192 (0x2000) and 8191 on channel 0 -> identical bit patterns on source_data.
- Start during CAPTURE and OUTPUT: pulse sink_start at E0+3 and E0+15 -> ignored; exactly one 3x8-word frame.
- Back-to-back frames: start exactly one cycle after the last valid word -> accepted; second frame identical in framing, with fresh data.
- Mid-readout reset: reset_n=0 at E0+12 -> outputs 0 the next cycle; after release, a new start produces a complete, correct frame.
